// File: rtl/fpu_issue_queue.sv
// rtl/fpu_issue_queue.sv - operand FIFO and single-issue sequencer in front of an FPU core
// Optional result classification is enabled by defining FPU_ISSUE_CLASSIFY_EN.

module fpu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_op,
  input  logic [3:0]  in_tag,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  input  logic [31:0] fpu_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_tag,
  output logic [2:0]  out_flags
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int WW   = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [3:0]  tag;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [WW-1:0]   wait_q, wait_d;
  state_t          state_q, state_d;

  logic [31:0]     fpu_a_q, fpu_b_q;
  logic [1:0]      fpu_op_q;
  logic [3:0]      pend_tag_q;
  logic [31:0]     result_q;
  logic [3:0]      tag_q;

  logic            push;
  logic            issue;
  logic            capture;
  logic            hold_valid;

  // Acceptance depends only on occupancy so a same-cycle pop never widens it.
  assign in_ready = (count_q < CNTW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  // Entry storage; pointers alone define which slots are live, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: in_a, b: in_b, op: in_op, tag: in_tag};
    end
  end

  // Circular-buffer pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !issue) begin
      count_d = count_q + CNTW'(1);
    end else if (!push && issue) begin
      count_d = count_q - CNTW'(1);
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: issue one op, wait out the core latency, hold the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: issue strobe, capture strobe and result-valid.
  always_comb begin
    issue      = 1'b0;
    capture    = 1'b0;
    hold_valid = 1'b0;
    case (state_q)
      IDLE:    issue      = (count_q != '0);
      WAIT:    capture    = (wait_q == '0);
      HOLD:    hold_valid = 1'b1;
      default: ;
    endcase
  end

  // Latency counter: loaded on issue, counts down to zero while waiting.
  always_comb begin
    wait_d = wait_q;
    if (issue) begin
      wait_d = WW'(LATENCY);
    end else if ((state_q == WAIT) && (wait_q != '0)) begin
      wait_d = wait_q - WW'(1);
    end
  end

  // Latency counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // Core operand registers; they keep the last issued op until the next pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_op_q   <= '0;
      pend_tag_q <= '0;
    end else if (issue) begin
      fpu_a_q    <= head.a;
      fpu_b_q    <= head.b;
      fpu_op_q   <= head.op;
      pend_tag_q <= head.tag;
    end
  end

  // Result capture; the held values stay stable through HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      tag_q    <= '0;
    end else if (capture) begin
      result_q <= fpu_o;
      tag_q    <= pend_tag_q;
    end
  end

`ifdef FPU_ISSUE_CLASSIFY_EN
  logic [2:0] flags_q;

  // {nan, inf, zero} classification of the captured result.
  function automatic logic [2:0] classify(input logic [31:0] v);
    logic exp_ones;
    logic exp_zero;
    logic frac_zero;
    exp_ones  = (v[30:23] == 8'hFF);
    exp_zero  = (v[30:23] == 8'h00);
    frac_zero = (v[22:0] == 23'd0);
    return {exp_ones && !frac_zero, exp_ones && frac_zero, exp_zero && frac_zero};
  endfunction

  // Flags are registered on the same edge as the result they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (capture) begin
      flags_q <= classify(fpu_o);
    end
  end

  assign out_flags = flags_q;
`else
  assign out_flags = 3'b000;
`endif

  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_op     = fpu_op_q;
  assign out_valid  = hold_valid;
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb/tb_fpu_issue_queue.sv - self-checking bench for fpu_issue_queue

module tb_fpu_issue_queue;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_o = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [2:0]  out_flags;

  int total = 0;
  int bad = 0;

  logic [38:0] exp_q[$];
  logic [38:0] got_q[$];
  int          rise_q[$];
  int          mcyc = 0;
  logic        ov_prev = 1'b0;

  fpu_issue_queue #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_o(fpu_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  function automatic real sp2r(input logic [31:0] v);
    logic [63:0] d;
    int e;
    if (v[30:23] == 8'd0) return 0.0;
    e = int'(v[30:23]) + 896;
    d = {v[31], e[10:0], v[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural stand-in for the FPU core arithmetic.
  function automatic logic [31:0] core_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    real ra;
    real rb;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
    ra = sp2r(a);
    rb = sp2r(b);
    case (op)
      2'd0: return r2sp(ra + rb);
      2'd1: return r2sp(ra - rb);
      2'd2: begin
        if (rb == 0.0) return {a[31] ^ b[31], 8'hFF, 23'd0};
        return r2sp(ra / rb);
      end
      default: return r2sp(ra * rb);
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] v);
`ifdef FPU_ISSUE_CLASSIFY_EN
    return {(v[30:23] == 8'hFF) && (v[22:0] != 0), (v[30:23] == 8'hFF) && (v[22:0] == 0),
            (v[30:23] == 8'h00) && (v[22:0] == 0)};
`else
    return 3'b000 & v[2:0] & 3'b000;
`endif
  endfunction

  function automatic logic [31:0] rand_operand();
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) return 32'h7F000000;
    if (k == 1) return 32'h00000000;
    return r2sp(real'(int'($urandom_range(0, 40)) - 20));
  endfunction

  // Core pipeline: LATENCY=1 register stage after the operand registers.
  always @(posedge clk) fpu_o <= core_f(fpu_a, fpu_b, fpu_op);

  // Record every result handshake and every out_valid rise.
  always @(posedge clk) begin
    mcyc <= mcyc + 1;
    ov_prev <= out_valid;
    if (out_valid === 1'b1 && ov_prev !== 1'b1) rise_q.push_back(mcyc);
    if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back({out_flags, out_tag, out_result});
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [3:0] tag);
    int w;
    logic [31:0] r;
    w = 0;
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); @(negedge clk); w++;
    end
    check("push_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    r = core_f(a, b, op);
    exp_q.push_back({ref_flags(r), tag, r});
  endtask

  task automatic wait_results(input string name, input int n, input int budget);
    int w;
    w = 0;
    while (got_q.size() < n && w < budget) begin
      @(negedge clk); w++;
    end
    check(name, 64'(got_q.size()), 64'(n));
  endtask

  task automatic compare_results(input string name);
    logic [38:0] g;
    logic [38:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 39'h7F_FFFF_FFFF;
      check(name, 64'(g), 64'(e));
    end
  endtask

  // Single op with out_ready low: checks operands, latency, result and hold.
  task automatic single(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [3:0] tag,
                        input logic [31:0] eres, input logic [2:0] eflags);
    int n;
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check({name, "_fpu_a"}, 64'(fpu_a), 64'(a));
    check({name, "_fpu_b"}, 64'(fpu_b), 64'(b));
    check({name, "_fpu_op"}, 64'(fpu_op), 64'(op));
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check({name, "_latency"}, 64'(n), 64'(LATENCY + 1));
    check({name, "_result"}, 64'(out_result), 64'(eres));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    check({name, "_flags"}, 64'(out_flags), 64'(eflags));
    @(posedge clk); @(negedge clk);
    check({name, "_hold"}, {31'd0, out_valid, out_result}, {31'd0, 1'b1, eres});
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({name, "_drop"}, {63'd0, out_valid}, 64'd0);
    check({name, "_keep_a"}, 64'(fpu_a), 64'(a));
    got_q.delete();
  endtask

  initial begin
    int acc;
    int r0;
    int base;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    logic [31:0] rr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_regs", {25'd0, out_flags, out_tag, out_result}, 64'd0);
    check("rst_fpu", {30'd0, fpu_op, fpu_a}, 64'd0);
    check("rst_fpu_b", 64'(fpu_b), 64'd0);
    rst_n = 1'b1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    single("add", 32'h3F800000, 32'h40000000, 2'b00, 4'd3, 32'h40400000, 3'b000);
    single("mul", 32'h40000000, 32'h40400000, 2'b11, 4'd5, 32'h40C00000, 3'b000);
`ifdef FPU_ISSUE_CLASSIFY_EN
    single("nan", 32'h7FC00000, 32'h3F800000, 2'b00, 4'd7, 32'h7FC00000, 3'b100);
`else
    single("nan", 32'h7FC00000, 32'h3F800000, 2'b00, 4'd7, 32'h7FC00000, 3'b000);
`endif

    // Backpressure: six offers with out_ready low, only five fit.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      ra = rand_operand(); rb = rand_operand(); rop = 2'($urandom_range(0, 3));
      in_a = ra; in_b = rb; in_op = rop; in_tag = 4'(i + 1); in_valid = 1'b1;
      if (in_ready === 1'b1) begin
        acc++;
        rr = core_f(ra, rb, rop);
        exp_q.push_back({ref_flags(rr), 4'(i + 1), rr});
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd5);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    wait_results("bp_count", 5, 200);
    compare_results("bp_order");
    check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;
    got_q.delete();

    // Reset while an op waits on the core with more entries behind it.
    push(32'h3F800000, 32'h3F800000, 2'b00, 4'd10);
    push(32'h40000000, 32'h3F800000, 2'b01, 4'd11);
    push(32'h40400000, 32'h40000000, 2'b11, 4'd12);
    check("rw_pre_valid", {63'd0, out_valid}, 64'd0);
    in_a = 32'h40800000; in_b = 32'h40000000; in_op = 2'b10; in_tag = 4'd13;
    in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    check("rw_in_ready", {63'd0, in_ready}, 64'd1);
    check("rw_out_valid", {63'd0, out_valid}, 64'd0);
    check("rw_regs", {25'd0, out_flags, out_tag, out_result}, 64'd0);
    check("rw_fpu_a", 64'(fpu_a), 64'd0);
    r0 = rise_q.size();
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("rw_no_rise", 64'(rise_q.size()), 64'(r0));
    check("rw_no_result", 64'(got_q.size()), 64'd0);
    push(32'h41000000, 32'h3F800000, 2'b01, 4'd9);
    wait_results("rw_after", 1, 50);
    compare_results("rw_after_val");
    got_q.delete();

    // Pointer wrap with continuous draining.
    repeat (3) @(negedge clk);
    base = rise_q.size();
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      push(rand_operand(), rand_operand(), 2'($urandom_range(0, 3)), 4'(i));
    end
    wait_results("wrap_count", 2 * DEPTH + 1, 400);
    compare_results("wrap_order");
    for (int i = base + 1; i < rise_q.size(); i++) begin
      check("wrap_spacing", 64'(rise_q[i] - rise_q[i-1]), 64'(LATENCY + 3));
    end
    check("wrap_rises", 64'(rise_q.size() - base), 64'(2 * DEPTH + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_queue.md
FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of operand FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter LATENCY, default 1, giving the fpu core result latency in clocks.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  queue can accept a request.
REQ-007 SHALL have port in_a  input  32  IEEE-754 single-precision operand A.
REQ-008 SHALL have port in_b  input  32  IEEE-754 single-precision operand B.
REQ-009 SHALL have port in_op  input  2  opcode: 00 ADD, 01 SUB, 10 DIV, 11 MUL.
REQ-010 SHALL have port in_tag  input  4  caller tag, returned with the result.
REQ-011 SHALL have port fpu_a  output  32  operand A to the fpu core, registered.
REQ-012 SHALL have port fpu_b  output  32  operand B to the fpu core, registered.
REQ-013 SHALL have port fpu_op  output  2  opcode to the fpu core, registered.
REQ-014 SHALL have port fpu_o  input  32  result from the fpu core.
REQ-015 SHALL have port out_valid  output  1  result valid.
REQ-016 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-017 SHALL have port out_result  output  32  captured fpu result.
REQ-018 SHALL have port out_tag  output  4  tag of the captured result.
REQ-019 SHALL have port out_flags  output  3  {nan, inf, zero} result class.

Function
REQ-020 Push SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal (count < DEPTH), independent of a same-cycle pop.
REQ-021 FIFO SHALL be a circular buffer with read and write pointers wrapping modulo DEPTH; count SHALL be unchanged on a simultaneous push and pop.
REQ-022 FSM SHALL have states IDLE, WAIT and HOLD, with one operation in flight at most.
REQ-023 IDLE with count > 0 SHALL pop the head, load fpu_a/fpu_b/fpu_op and the pending tag, load the wait counter with LATENCY, and move to WAIT; with count == 0 it SHALL stay in IDLE.
REQ-024 WAIT SHALL decrement the counter each cycle; the edge after the counter reaches 0 SHALL capture fpu_o into out_result and the tag into out_tag, then move to HOLD.
REQ-025 Issue-edge to out_valid-rise latency SHALL be LATENCY+1 clocks.
REQ-026 HOLD SHALL assert out_valid and keep out_result, out_tag and out_flags stable until out_ready is high; on that edge it SHALL move to IDLE.
REQ-027 Back-to-back issue spacing with out_ready held high SHALL be LATENCY+3 clocks.
REQ-028 fpu_a/fpu_b/fpu_op SHALL hold their last issued values until the next pop.
REQ-029 Results SHALL be returned in strict issue order.

Reset
REQ-030 When rst_n is sampled low, the block SHALL: reset pointers and count to 0, enter IDLE, clear the counter, drive out_valid=0, out_result=0, out_tag=0, out_flags=0 and fpu_a=fpu_b=0, fpu_op=0, and drive in_ready=1 after the reset edge.
REQ-031 Reset asserted mid-WAIT or mid-HOLD SHALL discard the in-flight operation and all queued entries; no result SHALL emerge for them.

Configuration
REQ-032 Macro FPU_ISSUE_CLASSIFY_EN SHALL control result classification.
REQ-033 With FPU_ISSUE_CLASSIFY_EN defined, out_flags SHALL be registered at capture as follows: nan = (exp==255 and frac!=0); inf = (exp==255 and frac==0); zero = (exp==0 and frac==0).
REQ-034 With FPU_ISSUE_CLASSIFY_EN undefined, out_flags SHALL be constant 3'b000.

Verification
REQ-035 Bench SHALL cover ADD: in_a=0x3F800000, in_b=0x40000000, op=00, tag=3 -> out_result=0x40400000, out_tag=3, out_valid rising 2 clocks after the issue edge (LATENCY=1).
REQ-036 Bench SHALL cover MUL: in_a=0x40000000, in_b=0x40400000, op=11 -> out_result=0x40C00000.
REQ-037 Bench SHALL cover backpressure: out_ready=0, push 6 requests -> 5 accepted (1 in flight plus 4 queued), in_ready=0 thereafter; release out_ready -> results arrive in tag order.
REQ-038 Bench SHALL cover classification (macro defined): ADD in_a=0x7FC00000, in_b=0x3F800000 -> out_flags=3'b100; without the macro -> out_flags=3'b000.
REQ-039 Bench SHALL cover reset during WAIT with 3 entries queued -> out_valid stays 0, count=0, in_ready=1 after the reset edge.
REQ-040 Bench SHALL cover pointer wrap: 2*DEPTH+1 sequential ops with out_ready=1 -> all results correct, in order, with issue spacing of 4 clocks.
